// File: rtl/comp_pkg.sv
// Shared definitions for the computation sequencer and the Computation_module steering muxes.
package comp_pkg;

  typedef enum logic [1:0] {
    OP_SERIAL   = 2'd0,
    OP_SYSTOLIC = 2'd1,
    OP_CUSTOM   = 2'd2,
    OP_ILLEGAL  = 2'd3
  } op_e;

  typedef enum logic [2:0] {
    StIdle,
    StSerRun,
    StCusRun,
    StSaWl,
    StSaGap,
    StSaFl,
    StFin,
    StErr
  } state_e;

  typedef enum logic [1:0] {
    C11 = 2'd0,
    C12 = 2'd1,
    C21 = 2'd2,
    C22 = 2'd3
  } tile_e;

  // computation_mode_sel encoding seen by the addr/we/q muxes
  localparam logic [1:0] MODE_SERIAL   = 2'd0;
  localparam logic [1:0] MODE_SYSTOLIC = 2'd1;
  localparam logic [1:0] MODE_CUSTOM   = 2'd2;

  localparam logic [7:0] SER_FEAT_BASE  = 8'h10;
  localparam logic [5:0] SA_FEAT_BASE   = 6'h10;
  localparam logic [5:0] SA_TILE_STRIDE = 6'h04;
  localparam logic [7:0] TIMEOUT        = 8'd255;

  function automatic logic [5:0] tile_base(input logic [1:0] tile);
    logic [5:0] tile_w;
    tile_w = {4'b0000, tile};
    return SA_FEAT_BASE + tile_w * SA_TILE_STRIDE;
  endfunction

endpackage

// File: rtl/sequencer_timeout_cnt.sv
// Per-state wait counter: cleared on state entry, flags the first cycle in a state and the timeout.
module sequencer_timeout_cnt #(
  parameter logic [7:0] Limit = 8'd255
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  input  logic en_i,
  output logic first_o,
  output logic hit_o
);

  logic [7:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != Limit)) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign first_o = (cnt_q == 8'd0);
  // Asserted on the cycle whose closing edge brings the count to Limit.
  assign hit_o   = en_i && (cnt_q == (Limit - 8'd1));

endmodule

// File: rtl/computation_sequencer.sv
// Op sequencer in front of Computation_module: steers mode, drives enables and tile addresses,
// and reports completion or error. All outputs are registered from the next-state values.
module computation_sequencer (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       start_i,
  input  logic [1:0] op_sel_i,
  input  logic       serial_mode_done_i,
  input  logic       weight_Preloader_done_i,
  input  logic       feature_Loader_done_i,
  input  logic       custom_mode_done_i,
  output logic [1:0] computation_mode_sel_o,
  output logic       serial_mode_en_o,
  output logic       Weight_Preloader_en_o,
  output logic       Feature_Loader_en_o,
  output logic       custom_mode_en_o,
  output logic       systolic_mode_o,
  output logic [1:0] c_reg_sel_o,
  output logic [7:0] serial_mode_feature_baseaddr_o,
  output logic [5:0] systolic_mode_feature_baseaddr_o,
  output logic       busy_o,
  output logic       op_done_o,
  output logic       op_err_o
);
  import comp_pkg::*;

  state_e     state_q, state_d;
  logic [1:0] op_q, op_d;
  logic [1:0] tile_q, tile_d;
  logic       first, hit, cnt_en;

  logic [1:0] mode_sel_q, mode_sel_d;
  logic       ser_en_q, ser_en_d, wl_en_q, wl_en_d, fl_en_q, fl_en_d, cus_en_q, cus_en_d;
  logic       sys_mode_q, sys_mode_d, busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic [1:0] c_sel_q, c_sel_d;
  logic [7:0] ser_base_q, ser_base_d;
  logic [5:0] sa_base_q, sa_base_d;

  assign cnt_en = state_q inside {StSerRun, StCusRun, StSaWl, StSaGap, StSaFl};

  sequencer_timeout_cnt #(
    .Limit(TIMEOUT)
  ) u_timeout_cnt (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .clear_i(state_d != state_q),
    .en_i   (cnt_en),
    .first_o(first),
    .hit_o  (hit)
  );

  // A done seen on the first cycle of a step is stale from the previous step.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    tile_d  = tile_q;
    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          op_d = op_sel_i;
          case (op_sel_i)
            OP_SERIAL:   state_d = StSerRun;
            OP_SYSTOLIC: state_d = StSaWl;
            OP_CUSTOM:   state_d = StCusRun;
            default:     state_d = StErr;
          endcase
        end
      end
      StSerRun: begin
        if (!first && serial_mode_done_i) state_d = StFin;
        else if (hit)                     state_d = StErr;
      end
      StCusRun: begin
        if (!first && custom_mode_done_i) state_d = StFin;
        else if (hit)                     state_d = StErr;
      end
      StSaWl: begin
        if (!first && weight_Preloader_done_i) begin
          state_d = StSaGap;
          tile_d  = C11;
        end else if (hit) begin
          state_d = StErr;
        end
      end
      StSaGap: begin
        if (!feature_Loader_done_i) state_d = StSaFl;
        else if (hit)               state_d = StErr;
      end
      StSaFl: begin
        if (!first && feature_Loader_done_i) begin
          if (tile_q == C22) begin
            state_d = StFin;
          end else begin
            tile_d  = tile_q + 2'd1;
            state_d = StSaGap;
          end
        end else if (hit) begin
          state_d = StErr;
        end
      end
      StFin:   state_d = StIdle;
      StErr:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    mode_sel_d = ((state_d == StIdle) || (state_d == StErr)) ? 2'd0 : op_d;
    ser_en_d   = (state_d == StSerRun);
    cus_en_d   = (state_d == StCusRun);
    wl_en_d    = (state_d == StSaWl);
    fl_en_d    = (state_d == StSaFl);
    sys_mode_d = (state_d == StSaFl);
    c_sel_d    = (state_d == StSaFl) ? tile_d : 2'd0;
    ser_base_d = (state_d == StSerRun) ? SER_FEAT_BASE : 8'd0;
    sa_base_d  = (state_d == StSaFl) ? tile_base(tile_d) : 6'd0;
    busy_d     = (state_d != StIdle);
    done_d     = (state_d == StFin);
    err_d      = (state_d == StErr);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= StIdle;
      op_q       <= 2'd0;
      tile_q     <= 2'd0;
      mode_sel_q <= 2'd0;
      ser_en_q   <= 1'b0;
      wl_en_q    <= 1'b0;
      fl_en_q    <= 1'b0;
      cus_en_q   <= 1'b0;
      sys_mode_q <= 1'b0;
      c_sel_q    <= 2'd0;
      ser_base_q <= 8'd0;
      sa_base_q  <= 6'd0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      tile_q     <= tile_d;
      mode_sel_q <= mode_sel_d;
      ser_en_q   <= ser_en_d;
      wl_en_q    <= wl_en_d;
      fl_en_q    <= fl_en_d;
      cus_en_q   <= cus_en_d;
      sys_mode_q <= sys_mode_d;
      c_sel_q    <= c_sel_d;
      ser_base_q <= ser_base_d;
      sa_base_q  <= sa_base_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign computation_mode_sel_o           = mode_sel_q;
  assign serial_mode_en_o                 = ser_en_q;
  assign Weight_Preloader_en_o            = wl_en_q;
  assign Feature_Loader_en_o              = fl_en_q;
  assign custom_mode_en_o                 = cus_en_q;
  assign systolic_mode_o                  = sys_mode_q;
  assign c_reg_sel_o                      = c_sel_q;
  assign serial_mode_feature_baseaddr_o   = ser_base_q;
  assign systolic_mode_feature_baseaddr_o = sa_base_q;
  assign busy_o                           = busy_q;
  assign op_done_o                        = done_q;
  assign op_err_o                         = err_q;

endmodule
